// File: rtl/chan_scan_mux_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | chan_scan_pkg : shared constants, state type and select-width fn   |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
package chan_scan_pkg;

  localparam int DEF_NCH     = 4;
  localparam int DEF_W       = 4;
  localparam int DEF_DWELL_W = 8;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [0:0] {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_e;

  // A 1:1 mux still needs a one-bit select port.
  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/chan_scan_mux_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | chan_scan_mux_if : control, channel data and output bundle         |
// | Revision         : 1.0                                             |
// +--------------------------------------------------------------------+
interface chan_scan_mux_if
  import chan_scan_pkg::*;
#(
  parameter int NCH     = DEF_NCH,
  parameter int W       = DEF_W,
  parameter int DWELL_W = DEF_DWELL_W
);
  localparam int SEL_W = sel_w(NCH);

  logic               ena;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic [NCH-1:0]     ch_mask;
  logic [DWELL_W-1:0] dwell;
  logic [NCH*W-1:0]   din;
  logic [W-1:0]       dout;
  logic [SEL_W-1:0]   cur_sel;
  logic               dout_valid;
  logic               wrap;

  modport master (
    output ena, mode, sel, ch_mask, dwell, din,
    input  dout, cur_sel, dout_valid, wrap
  );

  modport slave (
    input  ena, mode, sel, ch_mask, dwell, din,
    output dout, cur_sel, dout_valid, wrap
  );

endinterface
`default_nettype wire

// File: rtl/chan_scan_mux_rr_next_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_next_pick : first enabled index after cur, cur itself last      |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
module rr_next_pick #(
  parameter int NCH   = 4,
  parameter int SEL_W = 2
) (
  input  logic [NCH-1:0]   mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] next,
  output logic             found,
  output logic             wrapped
);

  // Distance 1..NCH from cur; cur itself is distance NCH so it loses ties.
  always_comb begin
    int d;
    int best_d;
    d      = 0;
    best_d = NCH + 1;
    next   = cur;
    found  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      d = i - int'(cur);
      if (d <= 0) d = d + NCH;
      if (mask[i] && (d < best_d)) begin
        best_d = d;
        next   = SEL_W'(i);
        found  = 1'b1;
      end
    end
    wrapped = found && (next <= cur);
  end

endmodule
`default_nettype wire

// File: rtl/chan_scan_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | chan_scan_mux : registered NCH:1 mux with manual and auto-scan     |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module chan_scan_mux
  import chan_scan_pkg::*;
#(
  parameter int NCH     = DEF_NCH,
  parameter int W       = DEF_W,
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic            clk,
  input  logic            rst_n,
  chan_scan_mux_if.slave  bus
);
  localparam int SEL_W = sel_w(NCH);

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
  logic [W-1:0]       dout_q, dout_d;
  logic               valid_q, valid_d;
  logic               wrap_q, wrap_d;

  logic [SEL_W-1:0]   sel_m;
  logic [DWELL_W-1:0] cnt_cur;
  logic [SEL_W-1:0]   pick_next;
  logic               pick_found;
  logic               pick_wrap;
  logic [W-1:0]       ch_data;
  logic               ch_en;

  rr_next_pick #(
    .NCH   (NCH),
    .SEL_W (SEL_W)
  ) u_pick (
    .mask    (bus.ch_mask),
    .cur     (cur_sel_q),
    .next    (pick_next),
    .found   (pick_found),
    .wrapped (pick_wrap)
  );

  always_comb begin
    sel_m   = (int'(bus.sel) >= NCH) ? '0 : bus.sel;
    // A scan entered from manual always begins a fresh dwell.
    cnt_cur = (state_q == ST_SCAN) ? cnt_q : '0;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_sel_d = cur_sel_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    wrap_d    = wrap_q;
    ch_data   = '0;
    ch_en     = 1'b0;
    if (bus.ena) begin
      state_d = (bus.mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
      wrap_d  = 1'b0;
      if (bus.mode == MODE_MANUAL) begin
        cnt_d = '0;
        if (|bus.ch_mask) cur_sel_d = sel_m;
      end else if (cnt_cur == bus.dwell) begin
        cnt_d = '0;
        if (pick_found) begin
          cur_sel_d = pick_next;
          wrap_d    = pick_wrap;
        end
      end else begin
        cnt_d = cnt_cur + DWELL_W'(1);
      end
      for (int i = 0; i < NCH; i++) begin
        if (cur_sel_d == SEL_W'(i)) begin
          ch_en   = bus.ch_mask[i];
          ch_data = bus.din[i*W +: W];
        end
      end
      valid_d = ch_en;
      dout_d  = ch_en ? ch_data : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_MANUAL;
      cnt_q     <= '0;
      cur_sel_q <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_sel_q <= cur_sel_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      wrap_q    <= wrap_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.cur_sel    = cur_sel_q;
  assign bus.dout_valid = valid_q;
  assign bus.wrap       = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_chan_scan_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_chan_scan_mux : scoreboard bench with a behavioural model       |
// | Revision         : 1.0                                             |
// +--------------------------------------------------------------------+
module tb_chan_scan_mux;
  localparam int NCH     = 4;
  localparam int W       = 4;
  localparam int DWELL_W = 8;
  localparam int SEL_W   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chan_scan_mux_if #(.NCH(NCH), .W(W), .DWELL_W(DWELL_W)) bus ();

  chan_scan_mux #(.NCH(NCH), .W(W), .DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int sel;
    int dout;
    int valid;
    int wrap;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int m_sel, m_cnt, m_dout, m_valid, m_wrap;
  int seq[12] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  int sparse[4] = '{1, 3, 1, 3};
  int sparse_wrap[4] = '{0, 0, 1, 0};

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sel = 0; m_cnt = 0; m_dout = 0; m_valid = 0; m_wrap = 0;
  endtask

  function automatic int bit_of(input int v, input int i);
    return (v >> i) & 1;
  endfunction

  // Reference: spec rules applied once per enabled clock edge.
  task automatic model_step(input bit e, input bit md, input int s,
                            input int mk, input int dw, input logic [15:0] d);
    int nxt;
    if (!e) return;
    m_wrap = 0;
    if (mk == 0) begin
      if (md) m_cnt = (m_cnt == dw) ? 0 : (m_cnt + 1) % 256;
      else    m_cnt = 0;
    end else if (!md) begin
      m_sel = (s >= NCH) ? 0 : s;
      m_cnt = 0;
    end else if (m_cnt == dw) begin
      m_cnt = 0;
      nxt = m_sel;
      for (int k = NCH; k >= 1; k--)
        if (bit_of(mk, (m_sel + k) % NCH) == 1) nxt = (m_sel + k) % NCH;
      m_wrap = (nxt <= m_sel) ? 1 : 0;
      m_sel  = nxt;
    end else begin
      m_cnt = (m_cnt + 1) % 256;
    end
    m_valid = bit_of(mk, m_sel);
    m_dout  = m_valid ? int'((d >> (m_sel * W)) & 16'hF) : 0;
  endtask

  task automatic cycle(input bit e, input bit md, input int s, input int mk,
                       input int dw, input logic [15:0] d);
    @(negedge clk);
    bus.ena     = e;
    bus.mode    = md;
    bus.sel     = SEL_W'(s);
    bus.ch_mask = NCH'(mk);
    bus.dwell   = DWELL_W'(dw);
    bus.din     = d;
    model_step(e, md, s, mk, dw, d);
    q.push_back('{m_sel, m_dout, m_valid, m_wrap});
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: pops one expectation per edge for which stimulus was issued.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("sb_cur_sel", int'(bus.cur_sel), x.sel);
        chk("sb_dout", int'(bus.dout), x.dout);
        chk("sb_dout_valid", int'(bus.dout_valid), x.valid);
        chk("sb_wrap", int'(bus.wrap), x.wrap);
      end
    end
  end

  initial begin
    logic [15:0] d;
    bit md;
    int dw;
    d = 16'hD8A3;
    bus.ena = 1'b1; bus.mode = 1'b0; bus.sel = '0; bus.ch_mask = '1;
    bus.dwell = '0; bus.din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_dout", int'(bus.dout), 0);
    chk("rst_cur_sel", int'(bus.cur_sel), 0);
    chk("rst_valid", int'(bus.dout_valid), 0);
    chk("rst_wrap", int'(bus.wrap), 0);
    @(negedge clk);
    rst_n = 1'b1;

    cycle(1, 0, 2, 'hF, 0, d); after_edge();
    chk("man_dout", int'(bus.dout), 8);
    chk("man_cur_sel", int'(bus.cur_sel), 2);
    chk("man_valid", int'(bus.dout_valid), 1);
    cycle(1, 0, 1, 'hD, 0, d); after_edge();
    chk("masked_dout", int'(bus.dout), 0);
    chk("masked_valid", int'(bus.dout_valid), 0);
    chk("masked_cur_sel", int'(bus.cur_sel), 1);

    cycle(1, 0, 0, 'hF, 2, d);
    for (int i = 0; i < 12; i++) begin
      cycle(1, 1, 0, 'hF, 2, d); after_edge();
      chk("scan_seq", int'(bus.cur_sel), seq[i]);
      chk("scan_wrap", int'(bus.wrap), (i == 11) ? 1 : 0);
    end

    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 0, 'hA, 0, d); after_edge();
      chk("sparse_seq", int'(bus.cur_sel), sparse[i]);
      chk("sparse_wrap", int'(bus.wrap), sparse_wrap[i]);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 0, 'h4, 0, d); after_edge();
      chk("single_sel", int'(bus.cur_sel), 2);
      chk("single_wrap", int'(bus.wrap), 1);
    end
    repeat (2) cycle(0, 1, 1, 'h3, 0, 16'h1234);
    after_edge();
    chk("wrap_held", int'(bus.wrap), 1);

    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 0, 'h0, 0, d); after_edge();
      chk("empty_sel", int'(bus.cur_sel), 2);
      chk("empty_valid", int'(bus.dout_valid), 0);
    end
    repeat (2) cycle(1, 1, 0, 'hF, 3, d);
    for (int i = 0; i < 5; i++) cycle(0, 0, 3, 'h1, 0, 16'h5555);
    after_edge();
    chk("freeze_sel", int'(bus.cur_sel), 2);
    chk("freeze_dout", int'(bus.dout), m_dout);
    repeat (2) cycle(1, 1, 0, 'hF, 3, d);
    after_edge();
    chk("resume_sel", int'(bus.cur_sel), 3);

    rst_n = 1'b0;
    #1;
    chk("arst_dout", int'(bus.dout), 0);
    chk("arst_cur_sel", int'(bus.cur_sel), 0);
    chk("arst_valid", int'(bus.dout_valid), 0);
    chk("arst_wrap", int'(bus.wrap), 0);
    #1;
    rst_n = 1'b1;
    model_reset();

    md = 1'b0;
    dw = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(19) == 0) md = ~md;
      if ($urandom_range(29) == 0) dw = int'($urandom_range(3));
      cycle(($urandom_range(9) != 0), md, int'($urandom_range(3)),
            ($urandom_range(7) == 0) ? 0 : int'($urandom_range(15)),
            dw, 16'($urandom));
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/chan_scan_mux.md
Name: chan_scan_mux

Overview:
- Parametrised, registered NCH:1 multiplexer of W-bit channels. Successor to the fixed 4:1 combinational mux.
- Two modes: manual (external select) and auto-scan (round-robin over enabled channels, dwelling a programmable number of cycles on each).
- Sits between the pin-level input channels and uo_out in the top-level wrapper.

Parameters:
- NCH, 4, number of input channels (2..16).
- W, 4, channel data width in bits.
- DWELL_W, 8, width of the dwell-length input and dwell counter.
- SEL_W, $clog2(NCH), select width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  clock enable; low freezes all state.
- mode  in  1  0 = manual, 1 = auto-scan.
- sel  in  SEL_W  manual channel select.
- ch_mask  in  NCH  per-channel enable; 1 = channel eligible.
- dwell  in  DWELL_W  auto-scan: cycles per channel minus one.
- din  in  NCH*W  packed channel data; channel i = din[i*W +: W].
- dout  out  W  registered selected data.
- cur_sel  out  SEL_W  channel index driving dout.
- dout_valid  out  1  dout comes from an enabled channel.
- wrap  out  1  one-cycle pulse when the scan wraps to a lower-or-equal index.

Behaviour:
- Reset (async assert, sync-safe deassert by top level): dout=0, cur_sel=0, dout_valid=0, wrap=0, dwell counter cnt=0, state=MANUAL.
- All state updates on rising clk only when ena=1. With ena=0, every register holds, including wrap (a pending pulse is held, not cleared).
- Latency: dout, dout_valid and cur_sel are registered. dout in cycle t+1 = din[cur_sel_next] sampled at edge t.
- States are MANUAL and SCAN; mode selects the state directly.
- MANUAL:
  - cur_sel <= sel. Out-of-range sel (>= NCH) maps to 0.
  - dout_valid <= ch_mask[sel].
  - dout <= masked ? 0 : channel data.
  - cnt <= 0; wrap <= 0.
- SCAN:
  - If cnt < dwell: cnt <= cnt+1, cur_sel holds.
  - If cnt == dwell: cnt <= 0 and cur_sel <= first enabled index searching cur_sel+1, cur_sel+2, … modulo NCH, including cur_sel itself last.
  - dwell=0 means advance every cycle.
  - wrap <= 1 for one cycle when an advance yields next index <= cur_sel. With a single enabled channel, every advance pulses wrap.
  - dout and dout_valid follow the newly selected channel in the same edge.
- Empty mask (ch_mask=0), either mode:
  - cur_sel holds, dout <= 0, dout_valid <= 0, wrap <= 0.
  - cnt keeps counting in SCAN but no advance occurs.
- Mask change mid-dwell: takes effect at the next advance. If the current channel becomes disabled, dout_valid drops on the next edge and dout reads 0, but the index is not abandoned until the dwell expires.
- MANUAL->SCAN: scanning starts from the current cur_sel with cnt=0. The first advance happens after dwell+1 cycles.
- SCAN->MANUAL: the next edge loads sel; cnt is cleared.
- Changing dwell mid-count: compared live. If the new dwell < cnt, advance when cnt wraps at 2^DWELL_W (documented, not an error).
- Reset mid-scan returns immediately to the reset values.

Decomposition:
- Shared package chan_scan_pkg: MODE_MANUAL/MODE_SCAN constants, default NCH/W/DWELL_W, and the SEL_W derivation function.
- One sub-module rr_next_pick: combinational round-robin search (inputs: mask, current index; outputs: next index, found, wrapped).
- Top level holds the counter, mode handling and output registers.

Test Plan:
- Reset/manual: rst_n low then high, mode=0, mask=4'b1111, din=16'hD8A3, sel=2 -> next edge dout=4'h8, cur_sel=2, dout_valid=1, wrap=0.
- Masked manual: sel=1, mask=4'b1101 -> dout=0, dout_valid=0, cur_sel=1.
- Scan dwell: mode=1, dwell=2, mask=4'b1111 from cur_sel=0 -> cur_sel sequence 0,0,0,1,1,1,2,2,2,3,3,3,0. wrap pulses only on the 3->0 edge.
- Sparse mask: dwell=0, mask=4'b1010 -> cur_sel 1,3,1,3. wrap on each 3->1. Single-bit mask 4'b0100 -> cur_sel stays 2, wrap every cycle.
- Empty mask and ena freeze: mask=0 in SCAN -> dout=0, dout_valid=0, cur_sel frozen. ena=0 for 5 cycles mid-dwell -> all outputs and cnt unchanged, and the sequence resumes exactly where it stopped.
- Async reset mid-scan: rst_n pulsed low between edges during cur_sel=3 -> outputs go to reset values immediately, without waiting for a clock.
